decode_ctrl: RTL
================

# decode_ctrl

Decode-stage controller for the 5-stage RV32I pipeline. It decodes the instruction held in IF/ID and drives `imm_src` to the immediate extender in the same cycle. It owns the ID/EX control-word register, which supports flush, hold and bubble insertion. It also detects load-use hazards against the instruction currently in EX and keeps a saturating count of illegal opcodes.

## Interface
Parameters:
- `ILL_CNT_W`, default 8: width of the illegal-opcode counter.

Ports:
- `clk` input 1: single clock; all state updates on its rising edge.
- `rst_n` input 1: reset is synchronous and active-low.
- `instr_i` input 32: instruction from IF/ID.
- `instr_valid_i` input 1: `instr_i` holds a real instruction.
- `flush_i` input 1: taken branch/jump; ID/EX is loaded with a bubble.
- `hold_i` input 1: downstream stall; ID/EX keeps its value.
- `imm_src_o` output 2: combinational immediate-format select to the extender (00 I, 01 S, 10 B, 11 J).
- `lu_stall_o` output 1: combinational load-use stall to PC/IF-ID enable logic.
- `ex_valid_o` output 1: ID/EX holds a real instruction.
- `ex_reg_write_o` output 1: ID/EX control field.
- `ex_mem_write_o` output 1: ID/EX control field.
- `ex_mem_read_o` output 1: ID/EX control field.
- `ex_alu_src_o` output 1: ID/EX control field.
- `ex_branch_o` output 1: ID/EX control field.
- `ex_jump_o` output 1: ID/EX control field.
- `ex_result_src_o` output 2: 00 ALU, 01 memory, 10 PC+4.
- `ex_alu_op_o` output 2: 00 add, 01 sub, 10 funct-decoded.
- `ex_funct3_o` output 3: registered `instr[14:12]`.
- `ex_funct7b5_o` output 1: registered `instr[30]`.
- `ex_rd_o` output 5: registered `instr[11:7]`.
- `ex_illegal_o` output 1: one-cycle flag in ID/EX for an illegal opcode.
- `ill_cnt_o` output ILL_CNT_W: saturating count of illegal opcodes.

## Operation
- Opcode decode is combinational:
  - lw 0000011: I, reg_write, mem_read, alu_src, result 01, alu_op 00.
  - addi-class 0010011: I, reg_write, alu_src, alu_op 10.
  - R-type 0110011: reg_write, alu_op 10; `imm_src` is 00.
  - sw 0100011: S, mem_write, alu_src, alu_op 00.
  - beq-class 1100011: B, branch, alu_op 01.
  - jal 1101111: J, reg_write, jump, result 10.
  - jalr 1100111: I, reg_write, jump, alu_src, result 10.
  - Any other opcode is illegal and `imm_src` is 00.
- Register-use rules:
  - rs1 `instr[19:15]` is used by every legal opcode except jal.
  - rs2 `instr[24:20]` is used only by R, S and B.
- Load-use detection:
  - Condition: `instr_valid_i & ex_valid_o & ex_mem_read_o & (ex_rd_o != 0)`, and a used rs equals `ex_rd_o`.
  - When the condition holds, `lu_stall_o` is 1, independent of `hold_i` and `flush_i`.
- ID/EX update priority, evaluated every edge:
  1. `!rst_n`: all fields are 0.
  2. `flush_i`: bubble.
  3. `hold_i`: keep current value.
  4. `lu_stall_o`: bubble.
  5. `!instr_valid_i`: bubble.
  6. Illegal opcode: bubble with `ex_illegal_o` set to 1.
  7. Otherwise: load the decoded control word with `ex_valid_o` set to 1.
- Bubble definition: every ID/EX field is 0, including `ex_valid_o` and `ex_illegal_o`.
- `ill_cnt_o` increments by 1 only when case 6 is taken. It saturates at all-ones and clears only on reset.

## Timing
- `imm_src_o` and `lu_stall_o` have zero-cycle latency from `instr_i` and from the ID/EX state.
- The ID/EX fields have one-cycle latency.
- Reset values: all registered outputs are 0. The combinational outputs then evaluate to `lu_stall_o` = 0 (because `ex_valid_o` = 0) and `imm_src_o` = decode of `instr_i`.
- Boundary conditions:
  - `flush_i` and `hold_i` both asserted: flush wins.
  - `flush_i` and a load-use hazard together: bubble; `lu_stall_o` is still 1.
  - A load-use stall lasts exactly one cycle, because the load leaves EX when the bubble enters.
  - An instruction with `rd` = x0 never creates a hazard.
  - An illegal opcode under `hold_i` or `flush_i` is not counted.
  - Reset asserted mid-stream: ID/EX is cleared on the next edge, and no hazard is reported on the following cycle.

## Structure
- Shared package `riscv_pkg` holds:
  - opcode localparams;
  - `IMM_I`, `IMM_S`, `IMM_B`, `IMM_J` encodings;
  - `RES_ALU`, `RES_MEM`, `RES_PC4`;
  - `ALUOP_ADD`, `ALUOP_SUB`, `ALUOP_FUNCT`;
  - a packed `ctrl_word_t` struct covering every ID/EX field.
- One sub-module, `main_decoder`, is combinational: opcode in, `ctrl_word_t`, `imm_src`, `illegal`, `uses_rs1` and `uses_rs2` out. The register, hazard logic and counter stay in `decode_ctrl`.

## Test plan
- Reset: hold `rst_n` = 0 for 2 cycles with `instr_i` = 0x00500093 (addi) → all ex_* = 0 and `ill_cnt_o` = 0; after release, `imm_src_o` = 00 and the next edge gives `ex_valid_o` = 1, `ex_reg_write_o` = 1, `ex_alu_src_o` = 1, `ex_rd_o` = 1.
- Format sweep:
  - sw 0x0020A223 → `imm_src_o` = 01.
  - beq 0x00208463 → `imm_src_o` = 10 and, one cycle later, `ex_branch_o` = 1, `ex_alu_op_o` = 01.
  - jal 0x008000EF → `imm_src_o` = 11 and `ex_result_src_o` = 10.
- Load-use: lw 0x0000A103, then add 0x001101B3 → `lu_stall_o` = 1 for exactly one cycle and a bubble enters ID/EX; add issues on the next cycle. Repeating with jal after lw gives no stall.
- Flush and hold:
  - `flush_i` and `hold_i` asserted together over a valid instruction → `ex_valid_o` = 0.
  - `hold_i` alone for 3 cycles → ID/EX fields unchanged.
- Illegal: lui 0x000012B7 → `ex_illegal_o` = 1 for one cycle, `ex_valid_o` = 0, `ill_cnt_o` = 1.
- Saturation: 300 consecutive illegal instructions (with `ILL_CNT_W` = 8) → `ill_cnt_o` holds at 255.

Source files
------------

// File: rtl/riscv_pkg.sv
// Shared RV32I decode definitions: opcodes, field encodings, ID/EX control word.
// Latency: n/a (types and constants only).
// Backpressure: n/a.
package riscv_pkg;

  localparam logic [6:0] OP_LOAD   = 7'b0000011;
  localparam logic [6:0] OP_IMM    = 7'b0010011;
  localparam logic [6:0] OP_REG    = 7'b0110011;
  localparam logic [6:0] OP_STORE  = 7'b0100011;
  localparam logic [6:0] OP_BRANCH = 7'b1100011;
  localparam logic [6:0] OP_JAL    = 7'b1101111;
  localparam logic [6:0] OP_JALR   = 7'b1100111;

  localparam logic [1:0] IMM_I = 2'b00;
  localparam logic [1:0] IMM_S = 2'b01;
  localparam logic [1:0] IMM_B = 2'b10;
  localparam logic [1:0] IMM_J = 2'b11;

  localparam logic [1:0] RES_ALU = 2'b00;
  localparam logic [1:0] RES_MEM = 2'b01;
  localparam logic [1:0] RES_PC4 = 2'b10;

  localparam logic [1:0] ALUOP_ADD   = 2'b00;
  localparam logic [1:0] ALUOP_SUB   = 2'b01;
  localparam logic [1:0] ALUOP_FUNCT = 2'b10;

  typedef struct packed {
    logic       valid;
    logic       reg_write;
    logic       mem_write;
    logic       mem_read;
    logic       alu_src;
    logic       branch;
    logic       jump;
    logic [1:0] result_src;
    logic [1:0] alu_op;
    logic [2:0] funct3;
    logic       funct7b5;
    logic [4:0] rd;
    logic       illegal;
  } ctrl_word_t;

  // A bubble is the all-zero control word.
  localparam ctrl_word_t CTRL_BUBBLE = '0;

endpackage

// File: rtl/main_decoder.sv
// Opcode-only main decoder: control bits, immediate format, register usage.
// Latency: purely combinational, zero cycles.
// Backpressure: none; output follows opcode every cycle.
module main_decoder
  import riscv_pkg::*;
(
  input  logic [6:0]  opcode,
  output ctrl_word_t  ctrl,
  output logic [1:0]  imm_src,
  output logic        illegal,
  output logic        uses_rs1,
  output logic        uses_rs2
);

  // Decode opcode; per-instruction fields (valid, funct3, rd) are filled by the caller.
  always_comb begin
    ctrl     = CTRL_BUBBLE;
    imm_src  = IMM_I;
    illegal  = 1'b0;
    uses_rs1 = 1'b1;
    uses_rs2 = 1'b0;
    case (opcode)
      OP_LOAD: begin
        ctrl.reg_write  = 1'b1;
        ctrl.mem_read   = 1'b1;
        ctrl.alu_src    = 1'b1;
        ctrl.result_src = RES_MEM;
        ctrl.alu_op     = ALUOP_ADD;
      end
      OP_IMM: begin
        ctrl.reg_write = 1'b1;
        ctrl.alu_src   = 1'b1;
        ctrl.alu_op    = ALUOP_FUNCT;
      end
      OP_REG: begin
        ctrl.reg_write = 1'b1;
        ctrl.alu_op    = ALUOP_FUNCT;
        uses_rs2       = 1'b1;
      end
      OP_STORE: begin
        imm_src        = IMM_S;
        ctrl.mem_write = 1'b1;
        ctrl.alu_src   = 1'b1;
        ctrl.alu_op    = ALUOP_ADD;
        uses_rs2       = 1'b1;
      end
      OP_BRANCH: begin
        imm_src     = IMM_B;
        ctrl.branch = 1'b1;
        ctrl.alu_op = ALUOP_SUB;
        uses_rs2    = 1'b1;
      end
      OP_JAL: begin
        imm_src         = IMM_J;
        ctrl.reg_write  = 1'b1;
        ctrl.jump       = 1'b1;
        ctrl.result_src = RES_PC4;
        uses_rs1        = 1'b0;
      end
      OP_JALR: begin
        ctrl.reg_write  = 1'b1;
        ctrl.jump       = 1'b1;
        ctrl.alu_src    = 1'b1;
        ctrl.result_src = RES_PC4;
      end
      default: begin
        illegal  = 1'b1;
        uses_rs1 = 1'b0;
      end
    endcase
  end

endmodule

// File: rtl/decode_ctrl.sv
// Decode-stage controller: ID/EX control register, load-use detect, illegal-opcode count.
// Latency: imm_src/lu_stall combinational; ID/EX fields one cycle.
// Backpressure: hold keeps ID/EX; flush and load-use stall insert bubbles.
module decode_ctrl
  import riscv_pkg::*;
#(
  parameter int ILL_CNT_W = 8
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic [31:0]          instr_i,
  input  logic                 instr_valid_i,
  input  logic                 flush_i,
  input  logic                 hold_i,
  output logic [1:0]           imm_src_o,
  output logic                 lu_stall_o,
  output logic                 ex_valid_o,
  output logic                 ex_reg_write_o,
  output logic                 ex_mem_write_o,
  output logic                 ex_mem_read_o,
  output logic                 ex_alu_src_o,
  output logic                 ex_branch_o,
  output logic                 ex_jump_o,
  output logic [1:0]           ex_result_src_o,
  output logic [1:0]           ex_alu_op_o,
  output logic [2:0]           ex_funct3_o,
  output logic                 ex_funct7b5_o,
  output logic [4:0]           ex_rd_o,
  output logic                 ex_illegal_o,
  output logic [ILL_CNT_W-1:0] ill_cnt_o
);

  localparam logic [ILL_CNT_W-1:0] CNT_ONE = 1;

  ctrl_word_t            dec;
  ctrl_word_t            ex_q;
  ctrl_word_t            ex_nxt;
  logic                  dec_illegal;
  logic                  uses_rs1;
  logic                  uses_rs2;
  logic                  lu_hazard;
  logic                  count_ill;
  logic [4:0]            rs1;
  logic [4:0]            rs2;
  logic [ILL_CNT_W-1:0]  ill_cnt;
  logic                  unused_instr_bit;

  assign rs1              = instr_i[19:15];
  assign rs2              = instr_i[24:20];
  assign unused_instr_bit = instr_i[31];

  main_decoder u_main_decoder (
    .opcode   (instr_i[6:0]),
    .ctrl     (dec),
    .imm_src  (imm_src_o),
    .illegal  (dec_illegal),
    .uses_rs1 (uses_rs1),
    .uses_rs2 (uses_rs2)
  );

  // Load in EX whose destination feeds a source of the instruction in ID.
  always_comb begin
    lu_hazard = instr_valid_i & ex_q.valid & ex_q.mem_read & (ex_q.rd != 5'd0) &
                ((uses_rs1 & (rs1 == ex_q.rd)) | (uses_rs2 & (rs2 == ex_q.rd)));
  end

  assign lu_stall_o = lu_hazard;

  // Prioritised choice of the next ID/EX word: flush, hold, stall, invalid, illegal, load.
  always_comb begin
    ex_nxt    = CTRL_BUBBLE;
    count_ill = 1'b0;
    if (flush_i) begin
      ex_nxt = CTRL_BUBBLE;
    end else if (hold_i) begin
      ex_nxt = ex_q;
    end else if (lu_hazard || !instr_valid_i) begin
      ex_nxt = CTRL_BUBBLE;
    end else if (dec_illegal) begin
      ex_nxt.illegal = 1'b1;
      count_ill      = 1'b1;
    end else begin
      ex_nxt          = dec;
      ex_nxt.valid    = 1'b1;
      ex_nxt.funct3   = instr_i[14:12];
      ex_nxt.funct7b5 = instr_i[30];
      ex_nxt.rd       = instr_i[11:7];
      ex_nxt.illegal  = 1'b0;
    end
  end

  // ID/EX control-word register with synchronous clear.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      ex_q <= CTRL_BUBBLE;
    end else begin
      ex_q <= ex_nxt;
    end
  end

  // Saturating count of illegal opcodes that actually reached ID/EX.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      ill_cnt <= '0;
    end else if (count_ill && (ill_cnt != '1)) begin
      ill_cnt <= ill_cnt + CNT_ONE;
    end
  end

  assign ex_valid_o      = ex_q.valid;
  assign ex_reg_write_o  = ex_q.reg_write;
  assign ex_mem_write_o  = ex_q.mem_write;
  assign ex_mem_read_o   = ex_q.mem_read;
  assign ex_alu_src_o    = ex_q.alu_src;
  assign ex_branch_o     = ex_q.branch;
  assign ex_jump_o       = ex_q.jump;
  assign ex_result_src_o = ex_q.result_src;
  assign ex_alu_op_o     = ex_q.alu_op;
  assign ex_funct3_o     = ex_q.funct3;
  assign ex_funct7b5_o   = ex_q.funct7b5;
  assign ex_rd_o         = ex_q.rd;
  assign ex_illegal_o    = ex_q.illegal;
  assign ill_cnt_o       = ill_cnt;

endmodule
